// File: rtl/iq_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : iq_scheduler_pkg
// Purpose  : Width constants shared by the issue-queue scheduler, its
//            handshake interface and the age-matrix sub-module.
// Contents : PREG_LENGTH - physical register tag width
// Revision : 1.0 - initial release
// ============================================================================
package iq_scheduler_pkg;

  // Physical register tag width, common to rename, entries and writeback.
  localparam int PREG_LENGTH = 7;

endpackage : iq_scheduler_pkg
`default_nettype wire

// File: rtl/iq_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface: iq_scheduler_if
// Purpose  : Dispatch and issue handshakes of one issue queue.
// Signals  : disp_valid/disp_ready - dispatch to queue enqueue handshake
//            issue_valid/issue_idx - selected entry offered to the FU
//            fu_ready              - FU accepts the offered entry
// Modports : master - scheduler side (drives disp_ready and issue_*)
//            slave  - dispatch/FU side (drives disp_valid and fu_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface iq_scheduler_if
  import iq_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
);

  logic             disp_valid;
  logic             disp_ready;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic             fu_ready;

  modport master (
    input  disp_valid,
    input  fu_ready,
    output disp_ready,
    output issue_valid,
    output issue_idx
  );

  modport slave (
    output disp_valid,
    output fu_ready,
    input  disp_ready,
    input  issue_valid,
    input  issue_idx
  );

endinterface : iq_scheduler_if
`default_nettype wire

// File: rtl/iq_age_matrix.sv
`default_nettype none
// ============================================================================
// Module   : iq_age_matrix
// Purpose  : Relative-age tracking for the issue-queue entries and
//            oldest-ready selection.
// Ports    : clock         - clock
//            reset_n       - synchronous active-low reset
//            enq_onehot    - entry being allocated this cycle (0 or 1 hot)
//            ready         - per-entry ready-to-issue vector
//            oldest_onehot - oldest ready entry (one-hot, 0 if none ready)
// Revision : 1.0 - initial release
// ============================================================================
module iq_age_matrix
  import iq_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] enq_onehot,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest_onehot
);

  // r_age[i][j] = 1 : entry i is older than entry j.
  logic [DEPTH-1:0] r_age [DEPTH];
  logic [DEPTH-1:0] w_blocked;

  // A newly allocated entry becomes younger than every other entry: its row
  // is cleared and its column is set. The row clear takes precedence, which
  // also keeps the diagonal at 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (enq_onehot[i]) begin
            r_age[i][j] <= 1'b0;
          end else if (enq_onehot[j]) begin
            r_age[i][j] <= 1'b1;
          end
        end
      end
    end
  end

  // An entry is blocked when any ready entry is older than it.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w_blocked[i] = w_blocked[i] | (ready[j] & r_age[j][i]);
      end
    end
  end

  assign oldest_onehot = ready & ~w_blocked;

endmodule : iq_age_matrix
`default_nettype wire

// File: rtl/iq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : iq_scheduler
// Purpose  : Allocation, age-ordered select and writeback wakeup for one
//            issue queue built from iq_entry instances.
// Ports    : clock, reset_n        - clock, synchronous active-low reset
//            flush                 - discard the whole queue this cycle
//            bus (master)          - dispatch and issue handshakes
//            enq_valid_vec         - one-hot enqueue write enable to entries
//            entry_valid/ready     - per-entry valid and ready_to_go
//            entry_prs1/prs2       - flattened per-entry source tags
//            wb_valid, wb_prd      - writeback broadcast
//            wakeup_src1/src2      - per-entry source wakeup strobes
//            issuing_vec           - one-hot issue strobe to entries
//            occupancy             - registered count of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module iq_scheduler
  import iq_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  iq_scheduler_if.master               bus,
  output logic [DEPTH-1:0]             enq_valid_vec,
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [DEPTH-1:0]             entry_ready,
  input  logic [DEPTH*PREG_LENGTH-1:0] entry_prs1,
  input  logic [DEPTH*PREG_LENGTH-1:0] entry_prs2,
  input  logic                         wb_valid,
  input  logic [PREG_LENGTH-1:0]       wb_prd,
  output logic [DEPTH-1:0]             wakeup_src1,
  output logic [DEPTH-1:0]             wakeup_src2,
  output logic [DEPTH-1:0]             issuing_vec,
  output logic [IDX_W:0]               occupancy
);

  localparam logic [DEPTH-1:0] c_one = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_enq_onehot;
  logic [DEPTH-1:0] w_oldest;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W-1:0] w_issue_idx;
  logic             w_disp_ready;
  logic             w_enq_fire;
  logic             w_issue_valid;
  logic             w_issue_fire;
  logic [IDX_W:0]   r_occupancy;

  // --------------------------------------------------------------------------
  // Allocation. An entry issuing this cycle is still valid, so it can never
  // be the enqueue target in the same cycle.
  // --------------------------------------------------------------------------
  assign w_free       = ~entry_valid;
  // x & (~x + 1) isolates the lowest set bit: the lowest-index free entry.
  assign w_enq_onehot = w_free & (~w_free + c_one);
  assign w_disp_ready = (|w_free) & ~flush;
  assign w_enq_fire   = bus.disp_valid & w_disp_ready;

  assign enq_valid_vec  = w_enq_onehot & {DEPTH{w_enq_fire}};
  assign bus.disp_ready = w_disp_ready;

  // --------------------------------------------------------------------------
  // Age tracking and oldest-ready select
  // --------------------------------------------------------------------------
  iq_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age_matrix (
    .clock         (clock),
    .reset_n       (reset_n),
    .enq_onehot    (enq_valid_vec),
    .ready         (entry_ready),
    .oldest_onehot (w_oldest)
  );

  // OR-encode of a one-hot vector.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_oldest[i]) begin
        w_sel_idx = w_sel_idx | IDX_W'(i);
      end
    end
  end

  // Selection is recomputed every cycle; a stalled offer may be displaced by
  // an older entry that becomes ready.
  assign w_issue_valid = (|entry_ready) & ~flush;
  assign w_issue_idx   = w_issue_valid ? w_sel_idx : '0;
  assign w_issue_fire  = w_issue_valid & bus.fu_ready;

  assign bus.issue_valid = w_issue_valid;
  assign bus.issue_idx   = w_issue_idx;
  assign issuing_vec     = (c_one << w_issue_idx) & {DEPTH{w_issue_fire}};

  // --------------------------------------------------------------------------
  // Writeback wakeup (combinational, same cycle as wb_valid)
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_wakeup
    assign wakeup_src1[i] = wb_valid & entry_valid[i] &
                            (entry_prs1[i*PREG_LENGTH +: PREG_LENGTH] == wb_prd);
    assign wakeup_src2[i] = wb_valid & entry_valid[i] &
                            (entry_prs2[i*PREG_LENGTH +: PREG_LENGTH] == wb_prd);
  end

  // --------------------------------------------------------------------------
  // Occupancy. Entries update on the same edge, so the count always tracks
  // the number of valid entries.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_occupancy <= '0;
    end else if (flush) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= r_occupancy + (IDX_W+1)'(w_enq_fire) - (IDX_W+1)'(w_issue_fire);
    end
  end

  assign occupancy = r_occupancy;

  a_occ_matches_valid : assert property (
    @(posedge clock) disable iff (!reset_n)
      $countones(entry_valid) == 32'(r_occupancy)
  );

  a_occ_bounded : assert property (
    @(posedge clock) disable iff (!reset_n)
      32'(r_occupancy) <= DEPTH
  );

endmodule : iq_scheduler
`default_nettype wire

// File: tb/tb_iq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_scheduler
// Purpose  : Self-checking bench for iq_scheduler. The issue-queue entries
//            are emulated by the bench; a reference model keeps the entries
//            in allocation order as a queue and derives every expected value
//            from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_scheduler;
  import iq_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam logic [DEPTH-1:0] ONE = 1;

  logic                         clock = 1'b0;
  logic                         reset_n;
  logic                         flush;
  logic                         wb_valid;
  logic [PREG_LENGTH-1:0]       wb_prd;
  logic [DEPTH-1:0]             enq_valid_vec;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0]             entry_ready;
  logic [DEPTH*PREG_LENGTH-1:0] entry_prs1;
  logic [DEPTH*PREG_LENGTH-1:0] entry_prs2;
  logic [DEPTH-1:0]             wakeup_src1;
  logic [DEPTH-1:0]             wakeup_src2;
  logic [DEPTH-1:0]             issuing_vec;
  logic [IDX_W:0]               occupancy;

  iq_scheduler_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  iq_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .bus           (bus),
    .enq_valid_vec (enq_valid_vec),
    .entry_valid   (entry_valid),
    .entry_ready   (entry_ready),
    .entry_prs1    (entry_prs1),
    .entry_prs2    (entry_prs2),
    .wb_valid      (wb_valid),
    .wb_prd        (wb_prd),
    .wakeup_src1   (wakeup_src1),
    .wakeup_src2   (wakeup_src2),
    .issuing_vec   (issuing_vec),
    .occupancy     (occupancy)
  );

  always #5 clock = ~clock;

  // ---------------- reference model / entry emulation ----------------
  logic [DEPTH-1:0]       m_valid = '0;
  logic [DEPTH-1:0]       m_rdy   = '0;
  logic [PREG_LENGTH-1:0] m_prs1 [DEPTH];
  logic [PREG_LENGTH-1:0] m_prs2 [DEPTH];
  int                     age_q [$];   // entry indices, oldest first
  bit                     enq_rdy;
  int                     checks = 0;
  int                     errors = 0;

  always_comb begin
    entry_valid = m_valid;
    entry_ready = m_valid & m_rdy;
    entry_prs1  = '0;
    entry_prs2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_prs1[i*PREG_LENGTH +: PREG_LENGTH] = m_prs1[i];
      entry_prs2[i*PREG_LENGTH +: PREG_LENGTH] = m_prs2[i];
    end
  end

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_oldest();
    for (int k = 0; k < age_q.size(); k++) if (m_rdy[age_q[k]]) return age_q[k];
    return -1;
  endfunction

  // One clock: fires are decided from the model before the edge, state is
  // applied just after it.
  task automatic tick();
    int fi, oi;
    bit enq, iss;
    fi  = m_free();
    oi  = m_oldest();
    enq = reset_n && !flush && bus.disp_valid && (fi >= 0);
    iss = reset_n && !flush && bus.fu_ready && (oi >= 0);
    @(posedge clock);
    #1;
    if (!reset_n || flush) begin
      m_valid = '0;
      m_rdy   = '0;
      age_q.delete();
    end else begin
      if (iss) begin
        m_valid[oi] = 1'b0;
        m_rdy[oi]   = 1'b0;
        for (int k = 0; k < age_q.size(); k++) begin
          if (age_q[k] == oi) begin
            age_q.delete(k);
            break;
          end
        end
      end
      if (enq) begin
        m_valid[fi] = 1'b1;
        m_rdy[fi]   = enq_rdy;
        m_prs1[fi]  = PREG_LENGTH'($urandom_range(0, 7));
        m_prs2[fi]  = PREG_LENGTH'($urandom_range(0, 7));
        age_q.push_back(fi);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_prd = '0; enq_rdy = 1'b0;
    bus.disp_valid = 1'b0; bus.fu_ready = 1'b0;
    tick(); tick();
    #1;
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %0b expected 1", bus.disp_ready); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b expected 0", bus.issue_valid); end
    checks++; if (issuing_vec !== '0) begin errors++; $display("FAIL reset_issuing_vec: got %0h expected 0", issuing_vec); end
    checks++; if (enq_valid_vec !== '0) begin errors++; $display("FAIL reset_enq_vec: got %0h expected 0", enq_valid_vec); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    reset_n = 1'b1;
    tick();
    #1;
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL post_reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL post_reset_disp_ready: got %0b expected 1", bus.disp_ready); end
  endtask

  task automatic test_fill();
    bus.disp_valid = 1'b1; enq_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      checks++; if (enq_valid_vec !== (ONE << k)) begin errors++; $display("FAIL fill_enq_vec[%0d]: got %0h expected %0h", k, enq_valid_vec, ONE << k); end
      tick();
    end
    #1;
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL fill_full_disp_ready: got %0b expected 0", bus.disp_ready); end
    checks++; if (enq_valid_vec !== '0) begin errors++; $display("FAIL fill_full_enq_vec: got %0h expected 0", enq_valid_vec); end
    checks++; if (occupancy !== 4'(DEPTH)) begin errors++; $display("FAIL fill_occupancy: got %0d expected %0d", occupancy, DEPTH); end
    bus.disp_valid = 1'b0;
  endtask

  task automatic test_full_enq_issue();
    m_rdy[0] = 1'b1; bus.fu_ready = 1'b1; bus.disp_valid = 1'b1;
    #1;
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_issue_disp_ready: got %0b expected 0", bus.disp_ready); end
    checks++; if (issuing_vec !== 8'h01) begin errors++; $display("FAIL full_issue_issuing_vec: got %0h expected 01", issuing_vec); end
    tick();
    bus.fu_ready = 1'b0;
    #1;
    checks++; if (enq_valid_vec !== 8'h01) begin errors++; $display("FAIL full_refill_enq_vec: got %0h expected 01", enq_valid_vec); end
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_refill_occupancy: got %0d expected 7", occupancy); end
    tick();
    bus.disp_valid = 1'b0;
  endtask

  task automatic test_age_order();
    int order [3] = '{3, 1, 5};
    for (int k = 0; k < 3; k++) begin
      m_rdy[order[k]] = 1'b1; bus.fu_ready = 1'b1; bus.disp_valid = 1'b0;
      #1;
      checks++; if (bus.issue_idx !== IDX_W'(order[k])) begin errors++; $display("FAIL age_free_idx[%0d]: got %0d expected %0d", k, bus.issue_idx, order[k]); end
      tick();
      bus.fu_ready = 1'b0; bus.disp_valid = 1'b1; enq_rdy = 1'b0;
      #1;
      checks++; if (enq_valid_vec !== (ONE << order[k])) begin errors++; $display("FAIL age_enq_vec[%0d]: got %0h expected %0h", k, enq_valid_vec, ONE << order[k]); end
      tick();
    end
    bus.disp_valid = 1'b0;
    m_rdy[3] = 1'b1; m_rdy[1] = 1'b1; m_rdy[5] = 1'b1; bus.fu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (!(bus.issue_valid === 1'b1 && bus.issue_idx === IDX_W'(order[k]))) begin errors++; $display("FAIL age_issue_order[%0d]: got valid=%0b idx=%0d expected valid=1 idx=%0d", k, bus.issue_valid, bus.issue_idx, order[k]); end
      tick();
    end
    bus.fu_ready = 1'b0;
  endtask

  task automatic test_wakeup();
    for (int i = 0; i < DEPTH; i++) begin
      m_prs1[i] = PREG_LENGTH'(40 + i);
      m_prs2[i] = PREG_LENGTH'(60 + i);
    end
    m_prs1[4] = 7'd17; m_prs2[4] = 7'd17;
    m_prs1[3] = 7'd17;   // entry 3 is invalid here and must not wake
    wb_valid = 1'b1; wb_prd = 7'd17;
    #1;
    checks++; if (wakeup_src1 !== 8'h10) begin errors++; $display("FAIL wakeup_src1_hit: got %0h expected 10", wakeup_src1); end
    checks++; if (wakeup_src2 !== 8'h10) begin errors++; $display("FAIL wakeup_src2_hit: got %0h expected 10", wakeup_src2); end
    wb_prd = 7'd18;
    #1;
    checks++; if (wakeup_src1 !== 8'h00) begin errors++; $display("FAIL wakeup_src1_miss: got %0h expected 00", wakeup_src1); end
    checks++; if (wakeup_src2 !== 8'h00) begin errors++; $display("FAIL wakeup_src2_miss: got %0h expected 00", wakeup_src2); end
    wb_valid = 1'b0; wb_prd = 7'd17;
    #1;
    checks++; if (wakeup_src1 !== 8'h00) begin errors++; $display("FAIL wakeup_no_wb: got %0h expected 00", wakeup_src1); end
  endtask

  task automatic test_flush();
    m_rdy[2] = 1'b1; m_rdy[6] = 1'b1;
    flush = 1'b1; bus.disp_valid = 1'b1; bus.fu_ready = 1'b1;
    #1;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %0b expected 0", bus.issue_valid); end
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL flush_disp_ready: got %0b expected 0", bus.disp_ready); end
    checks++; if (issuing_vec !== '0 || enq_valid_vec !== '0) begin errors++; $display("FAIL flush_strobes: got issuing=%0h enq=%0h expected 0 0", issuing_vec, enq_valid_vec); end
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre_occupancy: got %0d expected 5", occupancy); end
    tick();
    flush = 1'b0; bus.disp_valid = 1'b0; bus.fu_ready = 1'b0;
    #1;
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_post_occupancy: got %0d expected 0", occupancy); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL flush_post_disp_ready: got %0b expected 1", bus.disp_ready); end
  endtask

  task automatic test_fu_stall();
    bus.disp_valid = 1'b1; enq_rdy = 1'b0;
    repeat (3) tick();
    bus.disp_valid = 1'b0;
    m_rdy[2] = 1'b1; bus.fu_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_idx !== 3'd2) begin errors++; $display("FAIL stall_offer[%0d]: got valid=%0b idx=%0d expected valid=1 idx=2", c, bus.issue_valid, bus.issue_idx); end
      checks++; if (issuing_vec !== '0) begin errors++; $display("FAIL stall_issuing_vec[%0d]: got %0h expected 0", c, issuing_vec); end
      tick();
    end
    bus.fu_ready = 1'b1;
    #1;
    checks++; if (issuing_vec !== 8'h04) begin errors++; $display("FAIL stall_release_vec: got %0h expected 04", issuing_vec); end
    tick();
    bus.fu_ready = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL stall_occupancy: got %0d expected 2", occupancy); end
  endtask

  task automatic test_random();
    int fi, oi;
    logic             e_disp_ready, e_issue_valid;
    logic [DEPTH-1:0] e_enq, e_issuing, e_w1, e_w2;
    logic [IDX_W-1:0] e_idx;
    for (int c = 0; c < 400; c++) begin
      bus.disp_valid = ($urandom_range(0, 3) != 0);
      bus.fu_ready   = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 31) == 0);
      enq_rdy        = 1'($urandom_range(0, 1));
      m_rdy          = m_rdy | (DEPTH'($urandom) & DEPTH'($urandom) & m_valid);
      wb_valid       = 1'($urandom_range(0, 1));
      wb_prd         = PREG_LENGTH'($urandom_range(0, 7));
      #1;
      fi            = m_free();
      oi            = m_oldest();
      e_disp_ready  = (fi >= 0) && !flush;
      e_enq         = (bus.disp_valid && e_disp_ready) ? (ONE << fi) : '0;
      e_issue_valid = (oi >= 0) && !flush;
      e_idx         = e_issue_valid ? IDX_W'(oi) : '0;
      e_issuing     = (e_issue_valid && bus.fu_ready) ? (ONE << oi) : '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_w1[i] = wb_valid && m_valid[i] && (m_prs1[i] == wb_prd);
        e_w2[i] = wb_valid && m_valid[i] && (m_prs2[i] == wb_prd);
      end
      checks++; if (bus.disp_ready !== e_disp_ready) begin errors++; $display("FAIL rnd_disp_ready[%0d]: got %0b expected %0b", c, bus.disp_ready, e_disp_ready); end
      checks++; if (enq_valid_vec !== e_enq) begin errors++; $display("FAIL rnd_enq_vec[%0d]: got %0h expected %0h", c, enq_valid_vec, e_enq); end
      checks++; if (bus.issue_valid !== e_issue_valid) begin errors++; $display("FAIL rnd_issue_valid[%0d]: got %0b expected %0b", c, bus.issue_valid, e_issue_valid); end
      checks++; if (bus.issue_idx !== e_idx) begin errors++; $display("FAIL rnd_issue_idx[%0d]: got %0d expected %0d", c, bus.issue_idx, e_idx); end
      checks++; if (issuing_vec !== e_issuing) begin errors++; $display("FAIL rnd_issuing_vec[%0d]: got %0h expected %0h", c, issuing_vec, e_issuing); end
      checks++; if (occupancy !== (IDX_W+1)'(age_q.size())) begin errors++; $display("FAIL rnd_occupancy[%0d]: got %0d expected %0d", c, occupancy, age_q.size()); end
      checks++; if (wakeup_src1 !== e_w1 || wakeup_src2 !== e_w2) begin errors++; $display("FAIL rnd_wakeup[%0d]: got %0h/%0h expected %0h/%0h", c, wakeup_src1, wakeup_src2, e_w1, e_w2); end
      tick();
    end
    flush = 1'b0; bus.disp_valid = 1'b0; bus.fu_ready = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_prs1[i] = '0;
      m_prs2[i] = '0;
    end
    test_reset();
    test_fill();
    test_full_enq_issue();
    test_age_order();
    test_wakeup();
    test_flush();
    test_fu_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_iq_scheduler
`default_nettype wire
